// File: rtl/mem_lsu_pkg.sv
// Shared types, operation codes and helpers for the memory-stage load/store unit.
package mem_lsu_pkg;

  localparam int unsigned ALUOP_W = 8;
  localparam int unsigned REG_W   = 5;

  typedef logic [ALUOP_W-1:0] aluop_t;
  typedef logic [REG_W-1:0]   reg_addr_t;

  localparam reg_addr_t NOP_REG_ADDR = '0;

  // Load/store operation codes; any other code is a pass-through ALU result.
  localparam aluop_t EXE_ADD_OP = 8'h20;
  localparam aluop_t EXE_LB_OP  = 8'hE0;
  localparam aluop_t EXE_LH_OP  = 8'hE1;
  localparam aluop_t EXE_LW_OP  = 8'hE3;
  localparam aluop_t EXE_LBU_OP = 8'hE4;
  localparam aluop_t EXE_LHU_OP = 8'hE5;
  localparam aluop_t EXE_LWU_OP = 8'hE6;
  localparam aluop_t EXE_LD_OP  = 8'hE7;
  localparam aluop_t EXE_SB_OP  = 8'hE8;
  localparam aluop_t EXE_SH_OP  = 8'hE9;
  localparam aluop_t EXE_SW_OP  = 8'hEB;
  localparam aluop_t EXE_SD_OP  = 8'hEF;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2
  } lsu_state_e;

  // Access size codes, independent of XLEN; bytes = 1 << size.
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef struct packed {
    logic  is_mem;     // legal memory access for this XLEN
    logic  is_load;
    logic  sgn;        // sign-extend load result
    size_e size;
    logic  kill_wreg;  // 64-bit-only op on a 32-bit datapath
  } mem_op_t;

  // Decode an ALU op into memory-access attributes for the given datapath width.
  function automatic mem_op_t decode_op(input aluop_t op, input logic xlen64);
    mem_op_t d;
    d      = '0;
    d.size = SZ_B;
    case (op)
      EXE_LB_OP:  begin d.is_mem = 1'b1; d.is_load = 1'b1; d.sgn = 1'b1; d.size = SZ_B; end
      EXE_LBU_OP: begin d.is_mem = 1'b1; d.is_load = 1'b1; d.sgn = 1'b0; d.size = SZ_B; end
      EXE_LH_OP:  begin d.is_mem = 1'b1; d.is_load = 1'b1; d.sgn = 1'b1; d.size = SZ_H; end
      EXE_LHU_OP: begin d.is_mem = 1'b1; d.is_load = 1'b1; d.sgn = 1'b0; d.size = SZ_H; end
      EXE_LW_OP:  begin d.is_mem = 1'b1; d.is_load = 1'b1; d.sgn = 1'b1; d.size = SZ_W; end
      // On a 32-bit datapath LWU degenerates to LW.
      EXE_LWU_OP: begin d.is_mem = 1'b1; d.is_load = 1'b1; d.sgn = !xlen64; d.size = SZ_W; end
      EXE_LD_OP: begin
        if (xlen64) begin d.is_mem = 1'b1; d.is_load = 1'b1; d.size = SZ_D; end
        else        d.kill_wreg = 1'b1;
      end
      EXE_SB_OP:  begin d.is_mem = 1'b1; d.size = SZ_B; end
      EXE_SH_OP:  begin d.is_mem = 1'b1; d.size = SZ_H; end
      EXE_SW_OP:  begin d.is_mem = 1'b1; d.size = SZ_W; end
      EXE_SD_OP: begin
        if (xlen64) begin d.is_mem = 1'b1; d.size = SZ_D; end
        else        d.kill_wreg = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Request/grant/rvalid data-memory bus between the LSU (master) and memory (slave).
interface mem_lsu_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned NLANE = XLEN / 8;

  logic             mem_req_o;
  logic             mem_gnt_i;
  logic             mem_we_o;
  logic [XLEN-1:0]  mem_addr_o;
  logic [NLANE-1:0] mem_sel_o;
  logic [XLEN-1:0]  mem_data_o;
  logic             mem_rvalid_i;
  logic [XLEN-1:0]  mem_data_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o,
    input  mem_gnt_i, mem_rvalid_i, mem_data_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o,
    output mem_gnt_i, mem_rvalid_i, mem_data_i
  );
endinterface

// File: rtl/mem_lsu_align.sv
// Big-endian lane steering: byte enables, store replication, alignment and load extension.
module mem_lsu_align
  import mem_lsu_pkg::*;
#(
  parameter  int unsigned XLEN  = 32,
  localparam int unsigned NLANE = XLEN / 8,
  localparam int unsigned OFF_W = $clog2(NLANE)
) (
  input  size_e            req_size,
  input  logic [OFF_W-1:0] req_off,
  input  logic [XLEN-1:0]  req_data,
  output logic [NLANE-1:0] sel_c,
  output logic [XLEN-1:0]  rep_c,
  output logic             misalign_c,
  input  size_e            resp_size,
  input  logic [OFF_W-1:0] resp_off,
  input  logic             resp_sgn,
  input  logic [XLEN-1:0]  resp_data,
  output logic [XLEN-1:0]  load_c
);

  logic [3:0]       req_nb;
  logic [3:0]       resp_nb;
  logic [OFF_W-1:0] req_sh;
  logic [OFF_W-1:0] resp_sh;
  logic [NLANE-1:0] lane_mask;
  logic [XLEN-1:0]  shifted;

  assign req_nb  = 4'd1 << req_size;
  assign resp_nb = 4'd1 << resp_size;

  // Lowest lane used: byte offset k of an n-byte access ends at lane NLANE-n-k.
  assign req_sh  = OFF_W'(NLANE - 32'(req_nb) - 32'(req_off));
  assign resp_sh = OFF_W'(NLANE - 32'(resp_nb) - 32'(resp_off));

  assign misalign_c = |(req_off & OFF_W'(req_nb - 4'd1));
  assign lane_mask  = NLANE'((16'd1 << req_nb) - 16'd1);
  assign sel_c      = lane_mask << req_sh;

  // Replicate store data across every lane group of the access size.
  always_comb begin
    rep_c = req_data;
    case (req_size)
      SZ_B:    rep_c = {NLANE{req_data[7:0]}};
      SZ_H:    rep_c = {(NLANE/2){req_data[15:0]}};
      SZ_W:    rep_c = {(NLANE/4){req_data[31:0]}};
      default: rep_c = req_data;
    endcase
  end

  assign shifted = resp_data >> {resp_sh, 3'b000};

  // Right-justify the addressed lanes and sign/zero-extend to XLEN.
  always_comb begin
    load_c = shifted;
    case (resp_size)
      SZ_B:    load_c = resp_sgn ? XLEN'($signed(shifted[7:0]))  : XLEN'(shifted[7:0]);
      SZ_H:    load_c = resp_sgn ? XLEN'($signed(shifted[15:0])) : XLEN'(shifted[15:0]);
      SZ_W:    load_c = resp_sgn ? XLEN'($signed(shifted[31:0])) : XLEN'(shifted[31:0]);
      default: load_c = shifted;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit with a request/grant/rvalid handshake to data memory.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  aluop_t          aluop_i,
  input  reg_addr_t       wd_i,
  input  logic            wreg_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] mem_addr_i,
  input  logic [XLEN-1:0] reg2_i,
  mem_lsu_if.master       mem,
  output logic            wb_valid_o,
  output reg_addr_t       wd_o,
  output logic            wreg_o,
  output logic [XLEN-1:0] wdata_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] bad_addr_o,
  output logic            stallreq_o
);

  localparam int unsigned NLANE = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NLANE);

  lsu_state_e       state_q, state_d;
  mem_op_t          dec;
  logic [NLANE-1:0] sel_c;
  logic [XLEN-1:0]  rep_c;
  logic [XLEN-1:0]  load_c;
  logic             mis_c;

  logic             ld_q;
  logic             sgn_q;
  size_e            size_q;
  logic [OFF_W-1:0] off_q;
  reg_addr_t        wd_q;
  logic             wreg_q;

  logic acc_mem, acc_pass, acc_mis, done_st, done_ld;

  assign dec = decode_op(aluop_i, XLEN == 64);

  mem_lsu_align #(.XLEN(XLEN)) u_align (
    .req_size   (dec.size),
    .req_off    (mem_addr_i[OFF_W-1:0]),
    .req_data   (reg2_i),
    .sel_c      (sel_c),
    .rep_c      (rep_c),
    .misalign_c (mis_c),
    .resp_size  (size_q),
    .resp_off   (off_q),
    .resp_sgn   (sgn_q),
    .resp_data  (mem.mem_data_i),
    .load_c     (load_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= LSU_IDLE;
    else     state_q <= state_d;
  end

  // Next-state, handshake and completion strobes.
  always_comb begin
    state_d    = state_q;
    ex_ready_o = 1'b0;
    stallreq_o = 1'b0;
    acc_mem    = 1'b0;
    acc_pass   = 1'b0;
    acc_mis    = 1'b0;
    done_st    = 1'b0;
    done_ld    = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        ex_ready_o = 1'b1;
        if (ex_valid_i) begin
          if (!dec.is_mem) begin
            acc_pass = 1'b1;
          end else if (mis_c) begin
            acc_mis = 1'b1;
          end else begin
            acc_mem    = 1'b1;
            stallreq_o = 1'b1;
            state_d    = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        stallreq_o = 1'b1;
        if (mem.mem_gnt_i) begin
          if (!ld_q) begin
            done_st = 1'b1;
            state_d = LSU_IDLE;
          end else if (mem.mem_rvalid_i) begin
            done_ld = 1'b1;
            state_d = LSU_IDLE;
          end else begin
            state_d = LSU_WAIT;
          end
        end
      end
      LSU_WAIT: begin
        stallreq_o = 1'b1;
        if (mem.mem_rvalid_i) begin
          done_ld = 1'b1;
          state_d = LSU_IDLE;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  // Request latch, write-back result and misalign reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem.mem_req_o  <= 1'b0;
      mem.mem_we_o   <= 1'b0;
      mem.mem_addr_o <= '0;
      mem.mem_sel_o  <= '0;
      mem.mem_data_o <= '0;
      ld_q           <= 1'b0;
      sgn_q          <= 1'b0;
      size_q         <= SZ_B;
      off_q          <= '0;
      wd_q           <= NOP_REG_ADDR;
      wreg_q         <= 1'b0;
      wb_valid_o     <= 1'b0;
      wd_o           <= NOP_REG_ADDR;
      wreg_o         <= 1'b0;
      wdata_o        <= '0;
      misalign_o     <= 1'b0;
      bad_addr_o     <= '0;
    end else begin
      wb_valid_o    <= 1'b0;
      misalign_o    <= 1'b0;
      mem.mem_req_o <= (state_d == LSU_REQ);
      if (acc_mem) begin
        ld_q           <= dec.is_load;
        sgn_q          <= dec.sgn;
        size_q         <= dec.size;
        off_q          <= mem_addr_i[OFF_W-1:0];
        wd_q           <= wd_i;
        wreg_q         <= wreg_i;
        mem.mem_we_o   <= !dec.is_load;
        mem.mem_addr_o <= {mem_addr_i[XLEN-1:OFF_W], OFF_W'(0)};
        mem.mem_sel_o  <= sel_c;
        mem.mem_data_o <= dec.is_load ? '0 : rep_c;
      end
      if (acc_pass) begin
        wb_valid_o <= 1'b1;
        wd_o       <= wd_i;
        wreg_o     <= wreg_i & !dec.kill_wreg;
        wdata_o    <= wdata_i;
      end
      if (acc_mis) begin
        wb_valid_o <= 1'b1;
        wd_o       <= wd_i;
        wreg_o     <= 1'b0;
        wdata_o    <= '0;
        misalign_o <= 1'b1;
        bad_addr_o <= mem_addr_i;
      end
      if (done_st) begin
        wb_valid_o <= 1'b1;
        wd_o       <= wd_q;
        wreg_o     <= 1'b0;
        wdata_o    <= '0;
      end
      if (done_ld) begin
        wb_valid_o <= 1'b1;
        wd_o       <= wd_q;
        wreg_o     <= wreg_q;
        wdata_o    <= load_c;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu at XLEN=32 and XLEN=64 with a write-back scoreboard.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cur64, ex_valid, wreg, gnt, rvalid;
  aluop_t      aluop;
  reg_addr_t   wd;
  logic [63:0] wdata, addr, reg2, rdata;

  int checks = 0;
  int errors = 0;
  int wb_seen = 0;
  int pushed = 0;

  typedef struct {
    reg_addr_t   wd;
    logic        wreg;
    logic [63:0] wdata;
    logic        mis;
    logic        chk_data;
  } exp_t;
  exp_t sb[$];

  mem_lsu_if #(.XLEN(32)) if32 ();
  mem_lsu_if #(.XLEN(64)) if64 ();

  assign if32.mem_gnt_i    = gnt & ~cur64;
  assign if32.mem_rvalid_i = rvalid & ~cur64;
  assign if32.mem_data_i   = rdata[31:0];
  assign if64.mem_gnt_i    = gnt & cur64;
  assign if64.mem_rvalid_i = rvalid & cur64;
  assign if64.mem_data_i   = rdata;

  logic        r32_ready, r32_wb, r32_wreg, r32_mis, r32_stall;
  reg_addr_t   r32_wd;
  logic [31:0] r32_wdata, r32_bad;
  logic        r64_ready, r64_wb, r64_wreg, r64_mis, r64_stall;
  reg_addr_t   r64_wd;
  logic [63:0] r64_wdata, r64_bad;

  mem_lsu #(.XLEN(32)) u32 (
    .clk(clk), .rst(rst), .ex_valid_i(ex_valid & ~cur64), .ex_ready_o(r32_ready),
    .aluop_i(aluop), .wd_i(wd), .wreg_i(wreg), .wdata_i(wdata[31:0]),
    .mem_addr_i(addr[31:0]), .reg2_i(reg2[31:0]), .mem(if32),
    .wb_valid_o(r32_wb), .wd_o(r32_wd), .wreg_o(r32_wreg), .wdata_o(r32_wdata),
    .misalign_o(r32_mis), .bad_addr_o(r32_bad), .stallreq_o(r32_stall)
  );

  mem_lsu #(.XLEN(64)) u64 (
    .clk(clk), .rst(rst), .ex_valid_i(ex_valid & cur64), .ex_ready_o(r64_ready),
    .aluop_i(aluop), .wd_i(wd), .wreg_i(wreg), .wdata_i(wdata),
    .mem_addr_i(addr), .reg2_i(reg2), .mem(if64),
    .wb_valid_o(r64_wb), .wd_o(r64_wd), .wreg_o(r64_wreg), .wdata_o(r64_wdata),
    .misalign_o(r64_mis), .bad_addr_o(r64_bad), .stallreq_o(r64_stall)
  );

  // Observed view of whichever DUT is currently selected.
  logic        o_ready, o_wb, o_wreg, o_mis, o_stall, o_req, o_we;
  reg_addr_t   o_wd;
  logic [63:0] o_wdata, o_bad, o_addr, o_data;
  logic [7:0]  o_sel;

  always_comb begin
    if (cur64) begin
      o_ready = r64_ready; o_wb = r64_wb; o_wreg = r64_wreg; o_mis = r64_mis;
      o_stall = r64_stall; o_wd = r64_wd; o_wdata = r64_wdata; o_bad = r64_bad;
      o_req = if64.mem_req_o; o_we = if64.mem_we_o; o_addr = if64.mem_addr_o;
      o_data = if64.mem_data_o; o_sel = if64.mem_sel_o;
    end else begin
      o_ready = r32_ready; o_wb = r32_wb; o_wreg = r32_wreg; o_mis = r32_mis;
      o_stall = r32_stall; o_wd = r32_wd; o_wdata = {32'h0, r32_wdata}; o_bad = {32'h0, r32_bad};
      o_req = if32.mem_req_o; o_we = if32.mem_we_o; o_addr = {32'h0, if32.mem_addr_o};
      o_data = {32'h0, if32.mem_data_o}; o_sel = {4'h0, if32.mem_sel_o};
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input aluop_t op, input reg_addr_t d, input logic w,
                       input logic [63:0] wdat, input logic [63:0] a, input logic [63:0] r2);
    aluop = op; wd = d; wreg = w; wdata = wdat; addr = a; reg2 = r2;
    ex_valid = 1'b1;
    #1;
  endtask

  task automatic push(input reg_addr_t d, input logic w, input logic [63:0] wdat,
                      input logic mis, input logic chk_data);
    exp_t e;
    e.wd = d; e.wreg = w; e.wdata = wdat; e.mis = mis; e.chk_data = chk_data;
    sb.push_back(e);
    pushed++;
  endtask

  // Scoreboard: every write-back pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (o_wb) begin
      exp_t e;
      wb_seen++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL wb_unexpected observed=pulse wd=%0d expected=none", o_wd);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wb_wd", 64'(o_wd), 64'(e.wd));
        chk("wb_wreg", 64'(o_wreg), 64'(e.wreg));
        chk("wb_misalign", 64'(o_mis), 64'(e.mis));
        if (e.chk_data) chk("wb_wdata", o_wdata, e.wdata);
      end
    end
  end

  initial begin
    rst = 1'b1; cur64 = 1'b0; ex_valid = 1'b0; wreg = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    aluop = '0; wd = '0; wdata = '0; addr = '0; reg2 = '0; rdata = '0;
    tick(); tick();

    // Reset state, both widths.
    chk("rst_req32", 64'(o_req), 64'd0);
    chk("rst_wb32", 64'(o_wb), 64'd0);
    chk("rst_wd32", 64'(o_wd), 64'(NOP_REG_ADDR));
    chk("rst_sel32", 64'(o_sel), 64'd0);
    chk("rst_ready32", 64'(o_ready), 64'd1);
    chk("rst_stall32", 64'(o_stall), 64'd0);
    cur64 = 1'b1; #1;
    chk("rst_req64", 64'(o_req), 64'd0);
    chk("rst_wdata64", o_wdata, 64'd0);
    chk("rst_bad64", o_bad, 64'd0);
    cur64 = 1'b0;
    rst = 1'b0;
    tick();

    // 32-bit LB at byte offset 3, sign-extended.
    issue(EXE_LB_OP, 5'd3, 1'b1, 64'd0, 64'h103, 64'd0);
    chk("lb_stall", 64'(o_stall), 64'd1);
    push(5'd3, 1'b1, 64'hFFFF_FF80, 1'b0, 1'b1);
    tick(); ex_valid = 1'b0;
    chk("lb_req", 64'(o_req), 64'd1);
    chk("lb_sel", 64'(o_sel), 64'h01);
    chk("lb_addr", o_addr, 64'h100);
    chk("lb_we", 64'(o_we), 64'd0);
    chk("lb_ready", 64'(o_ready), 64'd0);
    gnt = 1'b1; rvalid = 1'b1; rdata = 64'h1122_3380;
    tick(); gnt = 1'b0; rvalid = 1'b0;
    chk("lb_req_drop", 64'(o_req), 64'd0);
    chk("lb_ready_back", 64'(o_ready), 64'd1);

    // 32-bit SH with grant delayed three cycles: request held stable for four.
    issue(EXE_SH_OP, 5'd4, 1'b1, 64'd0, 64'h202, 64'h0000_ABCD);
    chk("sh_stall_accept", 64'(o_stall), 64'd1);
    push(5'd4, 1'b0, 64'd0, 1'b0, 1'b0);
    tick(); ex_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("sh_req", 64'(o_req), 64'd1);
      chk("sh_sel", 64'(o_sel), 64'h03);
      chk("sh_data", o_data, 64'hABCD_ABCD);
      chk("sh_addr", o_addr, 64'h200);
      chk("sh_we", 64'(o_we), 64'd1);
      chk("sh_stall", 64'(o_stall), 64'd1);
      if (i == 3) gnt = 1'b1;
      tick();
    end
    gnt = 1'b0;
    chk("sh_req_drop", 64'(o_req), 64'd0);

    // 32-bit misaligned LW: no request, misalign pulse, address held.
    issue(EXE_LW_OP, 5'd6, 1'b1, 64'd0, 64'h206, 64'd0);
    chk("mis_stall", 64'(o_stall), 64'd0);
    push(5'd6, 1'b0, 64'd0, 1'b1, 1'b0);
    tick(); ex_valid = 1'b0;
    chk("mis_req", 64'(o_req), 64'd0);
    chk("mis_pulse", 64'(o_mis), 64'd1);
    chk("mis_bad", o_bad, 64'h206);
    tick();
    chk("mis_pulse_end", 64'(o_mis), 64'd0);
    chk("mis_bad_hold", o_bad, 64'h206);

    // 32-bit LD is a pass-through with the register write suppressed.
    issue(EXE_LD_OP, 5'd8, 1'b1, 64'h1234_5678, 64'h300, 64'd0);
    chk("ld32_stall", 64'(o_stall), 64'd0);
    push(5'd8, 1'b0, 64'h1234_5678, 1'b0, 1'b1);
    tick(); ex_valid = 1'b0;
    chk("ld32_req", 64'(o_req), 64'd0);
    tick();

    // 64-bit LWU at offset 4, rvalid two cycles after grant.
    cur64 = 1'b1;
    issue(EXE_LWU_OP, 5'd7, 1'b1, 64'd0, 64'h1004, 64'd0);
    push(5'd7, 1'b1, 64'h0000_0000_8000_0001, 1'b0, 1'b1);
    tick(); ex_valid = 1'b0;
    chk("lwu_sel", 64'(o_sel), 64'h0F);
    chk("lwu_addr", o_addr, 64'h1000);
    gnt = 1'b1;
    tick(); gnt = 1'b0;
    chk("lwu_wait_req", 64'(o_req), 64'd0);
    chk("lwu_wait_stall", 64'(o_stall), 64'd1);
    chk("lwu_wait_ready", 64'(o_ready), 64'd0);
    tick();
    rvalid = 1'b1; rdata = 64'h0000_0000_8000_0001;
    tick(); rvalid = 1'b0;

    // 64-bit LW at offset 0 uses the upper lanes and sign-extends.
    issue(EXE_LW_OP, 5'd7, 1'b1, 64'd0, 64'h1000, 64'd0);
    push(5'd7, 1'b1, 64'hFFFF_FFFF_8000_0001, 1'b0, 1'b1);
    tick(); ex_valid = 1'b0;
    chk("lw64_sel", 64'(o_sel), 64'hF0);
    gnt = 1'b1;
    tick(); gnt = 1'b0;
    rvalid = 1'b1; rdata = 64'h8000_0001_1234_5678;
    tick(); rvalid = 1'b0;

    // 64-bit SB replication and SD full-width store.
    issue(EXE_SB_OP, 5'd10, 1'b1, 64'd0, 64'h5, 64'h0000_0000_0000_00AB);
    push(5'd10, 1'b0, 64'd0, 1'b0, 1'b0);
    tick(); ex_valid = 1'b0;
    chk("sb64_sel", 64'(o_sel), 64'h04);
    chk("sb64_data", o_data, 64'hABAB_ABAB_ABAB_ABAB);
    gnt = 1'b1;
    tick(); gnt = 1'b0;
    issue(EXE_SD_OP, 5'd11, 1'b1, 64'd0, 64'h10, 64'h0123_4567_89AB_CDEF);
    push(5'd11, 1'b0, 64'd0, 1'b0, 1'b0);
    tick(); ex_valid = 1'b0;
    chk("sd64_sel", 64'(o_sel), 64'hFF);
    chk("sd64_data", o_data, 64'h0123_4567_89AB_CDEF);
    gnt = 1'b1;
    tick(); gnt = 1'b0;

    // Load with same-cycle grant and rvalid, then an ADD pass-through.
    issue(EXE_LH_OP, 5'd12, 1'b1, 64'd0, 64'h22, 64'd0);
    push(5'd12, 1'b1, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 1'b1);
    tick(); ex_valid = 1'b0;
    gnt = 1'b1; rvalid = 1'b1; rdata = 64'h0000_8001_0000_0000;
    tick(); gnt = 1'b0; rvalid = 1'b0;
    chk("b2b_ready", 64'(o_ready), 64'd1);
    issue(EXE_ADD_OP, 5'd9, 1'b1, 64'd5, 64'd0, 64'd0);
    chk("add_stall", 64'(o_stall), 64'd0);
    push(5'd9, 1'b1, 64'd5, 1'b0, 1'b1);
    tick(); ex_valid = 1'b0;
    chk("add_wb", 64'(o_wb), 64'd1);
    chk("add_wdata", o_wdata, 64'd5);
    tick();
    chk("add_wb_single", 64'(o_wb), 64'd0);

    // Reset while waiting for load data, then a stale rvalid.
    issue(EXE_LD_OP, 5'd13, 1'b1, 64'd0, 64'h2000, 64'd0);
    tick(); ex_valid = 1'b0;
    gnt = 1'b1;
    tick(); gnt = 1'b0;
    chk("rstw_stall", 64'(o_stall), 64'd1);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("rstw_req", 64'(o_req), 64'd0);
    chk("rstw_wb", 64'(o_wb), 64'd0);
    chk("rstw_wd", 64'(o_wd), 64'(NOP_REG_ADDR));
    chk("rstw_wdata", o_wdata, 64'd0);
    chk("rstw_sel", 64'(o_sel), 64'd0);
    chk("rstw_ready", 64'(o_ready), 64'd1);
    chk("rstw_stall_clr", 64'(o_stall), 64'd0);
    rvalid = 1'b1; rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    tick(); rvalid = 1'b0;
    chk("stale_wb", 64'(o_wb), 64'd0);
    issue(EXE_LD_OP, 5'd14, 1'b1, 64'd0, 64'h2008, 64'd0);
    push(5'd14, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1);
    tick(); ex_valid = 1'b0;
    chk("ld64_sel", 64'(o_sel), 64'hFF);
    chk("ld64_addr", o_addr, 64'h2008);
    gnt = 1'b1; rvalid = 1'b1; rdata = 64'h0123_4567_89AB_CDEF;
    tick(); gnt = 1'b0; rvalid = 1'b0;
    tick(); tick();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("wb_count", 64'(wb_seen), 64'(pushed));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
